// File: rtl/prog_lut_array_if.sv
// Bundle for the LUT array: evaluation pins plus the serial table-load port.
interface prog_lut_array_if #(
  parameter int unsigned ARITY    = 3,
  parameter int unsigned CHANNELS = 3
);
  logic [CHANNELS*ARITY-1:0] io_in;
  logic [CHANNELS-1:0]       io_out;
  logic                      out_valid;
  logic                      cfg_start;
  logic                      cfg_valid;
  logic                      cfg_data;
  logic                      cfg_ready;
  logic                      cfg_done;

  modport master (
    output io_in, cfg_start, cfg_valid, cfg_data,
    input  io_out, out_valid, cfg_ready, cfg_done
  );

  modport slave (
    input  io_in, cfg_start, cfg_valid, cfg_data,
    output io_out, out_valid, cfg_ready, cfg_done
  );
endinterface

// File: rtl/prog_lut_array.sv
// Run-time programmable array of CHANNELS independent ARITY-input LUTs.
// Tables load serially into a shadow buffer and swap into the active buffer on
// the final bit, so evaluation never sees a half-written table.
module prog_lut_array #(
  parameter int unsigned ARITY    = 3,
  parameter int unsigned CHANNELS = 3
) (
  input logic             clk,
  input logic             rst_n,
  prog_lut_array_if.slave bus
);
  localparam int unsigned TblSize = 1 << ARITY;
  localparam int unsigned TtBits  = CHANNELS * TblSize;
  localparam int unsigned CntW    = $clog2(TtBits);
  localparam int unsigned LastIdx = TtBits - 1;

  typedef enum logic [1:0] {StEmpty, StLoad, StActive} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [TtBits-1:0] shadow_q, shadow_d;
  logic [TtBits-1:0] active_q, active_d;
  // Set once any table has been swapped in; stays set through later reloads.
  logic              loaded_q, loaded_d;
  logic              done_q, done_d;
  logic [CHANNELS-1:0] lut_out;
  logic [CHANNELS-1:0] io_out_q;
  logic                out_valid_q;

  // Per-channel table lookup from the active buffer.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [ARITY-1:0]   idx;
    logic [TblSize-1:0] tbl;
    assign idx        = bus.io_in[c*ARITY +: ARITY];
    assign tbl        = active_q[c*TblSize +: TblSize];
    assign lut_out[c] = tbl[idx];
  end

  // Load FSM next-state: shadow fill, counter, swap on the last accepted bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    active_d = active_q;
    loaded_d = loaded_q;
    done_d   = 1'b0;
    unique case (state_q)
      StEmpty, StActive: begin
        if (bus.cfg_start) begin
          state_d = StLoad;
          cnt_d   = '0;
        end
      end
      StLoad: begin
        // A restart outranks any bit presented in the same cycle.
        if (bus.cfg_start) begin
          cnt_d = '0;
        end else if (bus.cfg_valid) begin
          shadow_d[cnt_q] = bus.cfg_data;
          if (cnt_q == CntW'(LastIdx)) begin
            active_d        = shadow_q;
            active_d[cnt_q] = bus.cfg_data;
            loaded_d        = 1'b1;
            done_d          = 1'b1;
            cnt_d           = '0;
            state_d         = StActive;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = StEmpty;
    endcase
  end

  // Load FSM and table storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StEmpty;
      cnt_q    <= '0;
      shadow_q <= '0;
      active_q <= '0;
      loaded_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      loaded_q <= loaded_d;
      done_q   <= done_d;
    end
  end

  // Registered outputs: held at 0 until a table exists, then the active lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      io_out_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      io_out_q    <= loaded_q ? lut_out : '0;
      out_valid_q <= out_valid_q | loaded_q;
    end
  end

  assign bus.io_out    = io_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.cfg_ready = (state_q == StLoad);
  assign bus.cfg_done  = done_q;
endmodule

// File: tb/tb_prog_lut_array.sv
// Directed bench for prog_lut_array (ARITY=3, CHANNELS=3).
module tb_prog_lut_array;
  localparam int unsigned ARITY = 3;
  localparam int unsigned CH    = 3;
  localparam int unsigned TT    = 24;
  localparam int unsigned CW    = 9;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Expected state of the design as seen before the next clock edge.
  logic [TT-1:0] exp_tbl;
  logic          exp_loaded;
  logic          exp_ov;

  prog_lut_array_if #(.ARITY(ARITY), .CHANNELS(CH)) bus ();

  prog_lut_array #(.ARITY(ARITY), .CHANNELS(CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CH-1:0] lut_model(input logic [TT-1:0] tbl,
                                              input logic [CW-1:0] in_v);
    logic [CH-1:0] res;
    logic [TT-1:0] sh;
    for (int c = 0; c < int'(CH); c++) begin
      sh     = tbl >> (c * 8 + int'(in_v[c*3 +: 3]));
      res[c] = sh[0];
    end
    return res;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One clock with io_in applied; checks outputs against the bench model.
  task automatic step(input logic [CW-1:0] in_v, input bit swap, input logic [TT-1:0] new_tbl);
    logic [CH-1:0] exp_out;
    bus.io_in = in_v;
    exp_out   = exp_loaded ? lut_model(exp_tbl, in_v) : '0;
    tick();
    exp_ov = exp_ov | exp_loaded;
    check("io_out", 32'(bus.io_out), 32'(exp_out));
    check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    check("cfg_done", 32'(bus.cfg_done), 32'(swap));
    if (swap) begin
      exp_tbl    = new_tbl;
      exp_loaded = 1'b1;
    end
  endtask

  // Serial load; gap_pct adds idle cycles, kill_last restarts on the final bit.
  task automatic load(input logic [TT-1:0] tbl, input int gap_pct, input bit kill_last);
    bus.cfg_valid = 1'b0;
    bus.cfg_start = 1'b1;
    step(CW'($urandom), 1'b0, tbl);
    bus.cfg_start = 1'b0;
    for (int k = 0; k < int'(TT); k++) begin
      for (int g = 0; g < 8 && int'($urandom_range(0, 99)) < gap_pct; g++) begin
        bus.cfg_valid = 1'b0;
        bus.cfg_data  = 1'($urandom);
        step(CW'($urandom), 1'b0, tbl);
      end
      check("cfg_ready", 32'(bus.cfg_ready), 32'd1);
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = tbl[k];
      if (k == int'(TT) - 1 && kill_last) bus.cfg_start = 1'b1;
      step(CW'($urandom), (k == int'(TT) - 1) && !kill_last, tbl);
      bus.cfg_start = 1'b0;
    end
    bus.cfg_valid = 1'b0;
    check("cfg_ready_end", 32'(bus.cfg_ready), 32'(kill_last));
    step(CW'($urandom), 1'b0, tbl);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    exp_tbl       = '0;
    exp_loaded    = 1'b0;
    exp_ov        = 1'b0;
    rst_n         = 1'b0;
    bus.io_in     = 9'h1FF;
    bus.cfg_start = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_data  = 1'b0;
    #12 rst_n = 1'b1;

    // 1: idle after reset with all inputs high.
    for (int i = 0; i < 5; i++) begin
      step(9'h1FF, 1'b0, '0);
      check("t1_ready", 32'(bus.cfg_ready), 32'd0);
    end

    // 2: AND3 / XOR3 / NOT in_0, loaded from EMPTY.
    load({8'h55, 8'h96, 8'h80}, 0, 1'b0);
    step(9'h01F, 1'b0, '0);
    check("t2_vec_a", 32'(bus.io_out), 32'b101);
    step(9'h07B, 1'b0, '0);
    check("t2_vec_b", 32'(bus.io_out), 32'b010);

    // 3: same table with idle gaps between bits.
    load({8'h55, 8'h96, 8'h80}, 30, 1'b0);
    step(9'h01F, 1'b0, '0);
    check("t3_vec", 32'(bus.io_out), 32'b101);

    // 4: reload all-ones while io_in toggles.
    load(24'hFFFFFF, 0, 1'b0);
    step(9'h000, 1'b0, '0);
    check("t4_vec", 32'(bus.io_out), 32'b111);

    // 5: restart on the final bit, then a clean load.
    load(24'h000000, 0, 1'b1);
    step(9'h000, 1'b0, '0);
    check("t5_old_tbl", 32'(bus.io_out), 32'b111);
    load(24'hF0F0F0, 0, 1'b0);
    step(9'h000, 1'b0, '0);
    check("t5_new_a", 32'(bus.io_out), 32'b000);
    step(9'h124, 1'b0, '0);
    check("t5_new_b", 32'(bus.io_out), 32'b111);

    // 6: asynchronous reset pulse while bit 10 is presented.
    bus.cfg_start = 1'b1;
    step(9'h1FF, 1'b0, '0);
    bus.cfg_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = k[0];
      step(9'h1FF, 1'b0, '0);
    end
    bus.cfg_data = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    check("t6_rst_out", 32'(bus.io_out), 32'd0);
    check("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_ready", 32'(bus.cfg_ready), 32'd0);
    #1 rst_n = 1'b1;
    exp_tbl    = '0;
    exp_loaded = 1'b0;
    exp_ov     = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = 1'($urandom);
      step(CW'($urandom), 1'b0, '0);
      check("t6_ready", 32'(bus.cfg_ready), 32'd0);
    end
    bus.cfg_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
